// File: rtl/comb_str_sync_pkg.sv
// Shared constants for the comb_str_sync function selector.
// Encodes which function the select line picks.
package comb_str_sync_pkg;

    localparam logic SEL_AND_OR = 1'b0;
    localparam logic SEL_EQ     = 1'b1;

endpackage

// File: rtl/comb_str_gates.sv
// Structural gate netlist for the selectable function.
// The two candidate functions are followed by a 2:1 AND-OR mux.
module comb_str_gates (
    output logic Y_comb,
    input  logic sel,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D
);

    logic sel_n;
    logic ab;
    logic cd;
    logic f_and_or;
    logic eq_ac;
    logic eq_bd;
    logic f_eq;
    logic leg_and_or;
    logic leg_eq;

    // AND-OR function of the two pairs
    and  g_ab    (ab, A, B);
    and  g_cd    (cd, C, D);
    or   g_f0    (f_and_or, ab, cd);

    // Pair equality: both bit positions must match
    xnor g_eq_ac (eq_ac, A, C);
    xnor g_eq_bd (eq_bd, B, D);
    and  g_f1    (f_eq, eq_ac, eq_bd);

    // Mux legs are AND-gated by sel and its complement, then ORed together
    not  g_sel_n (sel_n, sel);
    and  g_leg0  (leg_and_or, sel_n, f_and_or);
    and  g_leg1  (leg_eq, sel, f_eq);
    or   g_y     (Y_comb, leg_and_or, leg_eq);

endmodule

// File: rtl/comb_str_sync.sv
// Registered function selector: gate netlist followed by a single output flop,
// giving downstream control logic a glitch-free flag.
module comb_str_sync
    import comb_str_sync_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic Y,
    output logic Y_comb,
    input  logic sel,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D
);

    comb_str_gates u_gates (
        .Y_comb (Y_comb),
        .sel    (sel),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D)
    );

    // Output register: reset wins over capture in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Y <= 1'b0;
        end else begin
            Y <= Y_comb;
        end
    end

endmodule

// File: tb/tb_comb_str_sync.sv
// Self-checking bench for comb_str_sync: directed vectors, exhaustive sweep,
// mid-stream reset and intra-cycle toggling against a behavioural model.
module tb_comb_str_sync;

    logic clk = 1'b0;
    logic rst_n;
    logic Y;
    logic Y_comb;
    logic sel, A, B, C, D;

    int checks = 0;
    int errors = 0;

    logic    exp_y = 1'b0;
    bit      model_ok = 1'b0;
    realtime last_edge = 0;
    int      ones_and_or = 0;
    int      ones_eq = 0;

    comb_str_sync dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Y      (Y),
        .Y_comb (Y_comb),
        .sel    (sel),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D)
    );

    always #5 clk = ~clk;

    // Reference: treat {A,B} and {C,D} as 2-bit numbers
    function automatic logic model(input logic s, input logic a, input logic b,
                                   input logic c, input logic d);
        int ab;
        int cd;
        ab = (a ? 2 : 0) + (b ? 1 : 0);
        cd = (c ? 2 : 0) + (d ? 1 : 0);
        if (s) return (ab == cd);
        return (ab == 3) || (cd == 3);
    endfunction

    // Expected register value, updated on every rising edge
    always @(posedge clk) begin
        last_edge = $realtime;
        exp_y = rst_n ? model(sel, A, B, C, D) : 1'b0;
        model_ok = 1'b1;
    end

    // Continuous compare on the falling edge
    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (Y !== exp_y) begin
                errors++;
                $display("FAIL model_y t=%0t Y=%b expected=%b", $time, Y, exp_y);
            end
            checks++;
            if (Y_comb !== model(sel, A, B, C, D)) begin
                errors++;
                $display("FAIL model_ycomb t=%0t Y_comb=%b expected=%b", $time, Y_comb,
                         model(sel, A, B, C, D));
            end
        end
    end

    // Y may only move at a rising clock edge
    always @(Y) begin
        if (model_ok) begin
            checks++;
            if ($realtime != last_edge) begin
                errors++;
                $display("FAIL glitch t=%0t Y changed to %b off the clock edge", $time, Y);
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] v);
        {sel, A, B, C, D} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'b11111);
        #1;

        // Reset held for two edges
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset_y", Y, 1'b0);
            chk("reset_ycomb", Y_comb, 1'b1);
        end

        // AND-OR directed vectors
        rst_n = 1'b1;
        drive(5'b01100);
        #1;
        chk("andor_1100_comb", Y_comb, 1'b1);
        tick();
        chk("andor_1100", Y, 1'b1);
        drive(5'b01010);
        tick();
        chk("andor_1010", Y, 1'b0);
        drive(5'b00011);
        tick();
        chk("andor_0011", Y, 1'b1);

        // Equality directed vectors
        drive(5'b11010);
        tick();
        chk("eq_1010", Y, 1'b1);
        drive(5'b11001);
        tick();
        chk("eq_1001", Y, 1'b0);
        drive(5'b10000);
        tick();
        chk("eq_0000", Y, 1'b1);

        // Exhaustive sweep with a one-edge reset pulse at 01111
        for (int code = 0; code < 32; code++) begin
            drive(code[4:0]);
            rst_n = (code == 15) ? 1'b0 : 1'b1;
            #1;
            if (Y_comb === 1'b1) begin
                if (code < 16) ones_and_or++;
                else ones_eq++;
            end
            tick();
            if (code == 15) chk("midreset_y", Y, 1'b0);
            if (code == 16) chk("resume_after_reset", Y, 1'b1);
        end
        rst_n = 1'b1;
        checks++;
        if (ones_and_or != 7) begin
            errors++;
            $display("FAIL count_and_or got=%0d expected=7", ones_and_or);
        end
        checks++;
        if (ones_eq != 4) begin
            errors++;
            $display("FAIL count_eq got=%0d expected=4", ones_eq);
        end

        // Intra-cycle toggling of A and C with B=D=1, sel=0 (Y_comb = A | C)
        drive(5'b00101);
        tick();
        chk("glitch_start", Y, 1'b0);
        A = 1'b1; #1; C = 1'b1; #1; A = 1'b0; #1; C = 1'b0; #1; A = 1'b1;
        tick();
        chk("glitch_sample_1", Y, 1'b1);
        C = 1'b1; #1; A = 1'b0; #1; A = 1'b1; #1; C = 1'b0; #1; A = 1'b0;
        tick();
        chk("glitch_sample_0", Y, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
